mrd_fsm_ctrl: RTL and testbench
===============================

// Module: mrd_fsm_ctrl
// PURPOSE
//  Top-level sequencer for the mixed-radix DFT 7-bank memory. Drives the shared fsm[2:0] bus consumed
//  by the sink writer, read engine and source engine. Times sink, per-stage read passes, write-back
//  drain and output. Tracks frame size in bank rows. Recovers from sink timeout.
// PARAMETERS
//  wADDR    8   bank row address width
//  WAIT_RD  4   idle cycles between end of sink and first stage read
//  LAT_WR   16  butterfly+twiddle pipeline latency; drain cycles after last read of a stage
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      sink sample valid; a frame is one contiguous valid burst
//  in_ready     out  1      1 in Idle/Sink only; upstream must not assert in_valid otherwise
//  overTime     in   1      sink timeout from sink writer
//  num_stages   in   3      radix stages per frame; sampled at Idle->Sink; 0 treated as 1
//  fsm          out  3      Idle=0 Sink=1 Wait_to_rd=2 Rd=3 Wait_wr_end=4 Source=5
//  rd_en        out  1      stage read strobe, one row per cycle
//  rd_row       out  wADDR  row being read
//  stage        out  3      current stage index, 0-based
//  stage_sop    out  1      1 on first rd_en of each stage
//  src_valid    out  1      output sample valid
//  src_ready    in   1      downstream accept
//  src_cnt      out  12     index of current output sample
//  done         out  1      1-cycle pulse after last source handshake
//  err_timeout  out  1      1-cycle pulse on sink abort
// BEHAVIOUR
//  Reset: fsm=Idle. All outputs 0 except in_ready=1. All counters and latches cleared. Async assert,
//   sync deassert.
//  Sink accounting: bank_idx 0..6 and row_cnt advance on each in_valid cycle. bank_idx 6->0 increments
//   row_cnt. smp_cnt(12b) counts samples.
//  rows_total = row_cnt + (bank_idx!=0), latched at Sink exit.
//  Idle: in_valid=1 -> Sink. The first sample is counted on the same cycle.
//   Latch ns = (num_stages==0)?1:num_stages.
//  Sink:
//   - in_valid=0 -> Wait_to_rd. Latch rows_total and N=smp_cnt.
//   - overTime=1 -> Idle with err_timeout pulse and all counters cleared. overTime wins over in_valid=0
//     on the same cycle.
//  Wait_to_rd: counts WAIT_RD cycles, then Rd with stage=0 and rd_row=0.
//  Rd:
//   - rd_en=1 every cycle. rd_row increments each cycle.
//   - stage_sop=1 when rd_row==0.
//   - After rd_row==rows_total-1 -> Wait_wr_end. rd_en drops the next cycle.
//  Wait_wr_end: counts LAT_WR cycles, then:
//   - if stage==ns-1 -> Source with src_cnt=0;
//   - else stage+1 and Rd with rd_row=0.
//  Source:
//   - src_valid=1. src_cnt increments on src_valid&src_ready.
//   - A handshake at src_cnt==N-1 -> Idle with done pulse the following cycle. stage and src_cnt clear.
//   - src_ready=0 stalls src_cnt indefinitely; there is no timeout in Source.
//  in_valid outside Idle/Sink is ignored: no counter changes and no state change.
//  Outputs are registered. fsm changes on the cycle after the transition condition is sampled.
//  Widths: rows_total fits wADDR. N<=4095. Counters wrap naturally; no saturation is required.
//  Reset mid-operation returns to Idle immediately. No done or err pulse is issued.
// TESTING
//  1. N=14, ns=1:
//     - Sink lasts 14 cycles. rows_total=2.
//     - Rd is 2 cycles, rows 0,1. stage_sop on row 0.
//     - Source gives 14 handshakes, then done.
//  2. N=15, ns=3:
//     - rows_total=3.
//     - Three Rd passes with stage=0,1,2, each followed by exactly LAT_WR Wait_wr_end cycles.
//     - Then Source.
//  3. overTime at sink cycle 2047 with in_valid held high:
//     - err_timeout pulse. fsm=Idle next cycle.
//     - A following N=7 frame runs normally.
//  4. ns=0, N=7:
//     - Behaves exactly as ns=1: single stage, rows_total=1.
//     - One-cycle Rd with stage_sop=1.
//  5. Source N=21 with src_ready toggling 1,0,0,1...:
//     - src_cnt advances only on ready.
//     - Exactly 21 handshakes, then done once.
//  6. rst_n low during Rd of stage 1:
//     - Outputs reset asynchronously. fsm=Idle. No done pulse.
//     - in_valid during Rd before the reset is ignored.

Source files
------------

// File: rtl/mrd_fsm_ctrl_if.sv
// Control bus between the mixed-radix DFT sequencer and its sink, read and source engines.
// master: the sequencer (mrd_fsm_ctrl). It samples sink and source handshakes and drives the
//         fsm bus, the read strobes, the source counters and the status pulses.
// slave : the upstream and downstream side. It drives in_valid, overTime, num_stages and src_ready.
interface mrd_fsm_ctrl_if #(
    parameter int unsigned wADDR = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             overTime;
    logic [2:0]       num_stages;
    logic [2:0]       fsm;
    logic             rd_en;
    logic [wADDR-1:0] rd_row;
    logic [2:0]       stage;
    logic             stage_sop;
    logic             src_valid;
    logic             src_ready;
    logic [11:0]      src_cnt;
    logic             done;
    logic             err_timeout;

    modport master (
        input  in_valid, overTime, num_stages, src_ready,
        output in_ready, fsm, rd_en, rd_row, stage, stage_sop,
               src_valid, src_cnt, done, err_timeout
    );

    modport slave (
        output in_valid, overTime, num_stages, src_ready,
        input  in_ready, fsm, rd_en, rd_row, stage, stage_sop,
               src_valid, src_cnt, done, err_timeout
    );
endinterface

// File: rtl/mrd_fsm_ctrl.sv
// Top-level sequencer for the mixed-radix DFT 7-bank memory.
// It times the sink burst, the per-stage read passes, the write-back drain and the output burst,
// and it drives the shared fsm[2:0] bus. It also recovers from a sink timeout.
// Ports: clk, rst_n (async active-low) and bus (mrd_fsm_ctrl_if.master). All outputs are registered.
module mrd_fsm_ctrl #(
    parameter int unsigned wADDR   = 8,
    parameter int unsigned WAIT_RD = 4,
    parameter int unsigned LAT_WR  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mrd_fsm_ctrl_if.master bus
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned TMR_MAX = (WAIT_RD > LAT_WR) ? WAIT_RD : LAT_WR;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SINK    = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_RD      = 3'd3,
        ST_WAIT_WR = 3'd4,
        ST_SOURCE  = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [2:0]         bank_q,      bank_d;
    logic [wADDR-1:0]   row_q,       row_d;
    logic [CNT_W-1:0]   smp_q,       smp_d;
    logic [wADDR-1:0]   rows_tot_q,  rows_tot_d;
    logic [CNT_W-1:0]   n_q,         n_d;
    logic [2:0]         ns_q,        ns_d;
    logic [TMR_W-1:0]   tmr_q,       tmr_d;
    logic               in_ready_q,  in_ready_d;
    logic               rd_en_q,     rd_en_d;
    logic [wADDR-1:0]   rd_row_q,    rd_row_d;
    logic [2:0]         stage_q,     stage_d;
    logic               sop_q,       sop_d;
    logic               src_valid_q, src_valid_d;
    logic [CNT_W-1:0]   src_cnt_q,   src_cnt_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= '0;
            row_q       <= '0;
            smp_q       <= '0;
            rows_tot_q  <= '0;
            n_q         <= '0;
            ns_q        <= '0;
            tmr_q       <= '0;
            in_ready_q  <= 1'b1;
            rd_en_q     <= 1'b0;
            rd_row_q    <= '0;
            stage_q     <= '0;
            sop_q       <= 1'b0;
            src_valid_q <= 1'b0;
            src_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            smp_q       <= smp_d;
            rows_tot_q  <= rows_tot_d;
            n_q         <= n_d;
            ns_q        <= ns_d;
            tmr_q       <= tmr_d;
            in_ready_q  <= in_ready_d;
            rd_en_q     <= rd_en_d;
            rd_row_q    <= rd_row_d;
            stage_q     <= stage_d;
            sop_q       <= sop_d;
            src_valid_q <= src_valid_d;
            src_cnt_q   <= src_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        row_d       = row_q;
        smp_d       = smp_q;
        rows_tot_d  = rows_tot_q;
        n_d         = n_q;
        ns_d        = ns_q;
        tmr_d       = tmr_q;
        rd_en_d     = rd_en_q;
        rd_row_d    = rd_row_q;
        stage_d     = stage_q;
        sop_d       = 1'b0;
        src_valid_d = src_valid_q;
        src_cnt_d   = src_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The first sample is accounted on the same cycle as the start.
                if (bus.in_valid) begin
                    state_d = ST_SINK;
                    bank_d  = 3'd1;
                    row_d   = '0;
                    smp_d   = CNT_W'(1);
                    ns_d    = (bus.num_stages == 3'd0) ? 3'd1 : bus.num_stages;
                end
            end
            ST_SINK: begin
                if (bus.overTime) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    bank_d  = '0;
                    row_d   = '0;
                    smp_d   = '0;
                end else if (!bus.in_valid) begin
                    state_d    = ST_WAIT_RD;
                    rows_tot_d = row_q + wADDR'(bank_q != 3'd0);
                    n_d        = smp_q;
                    tmr_d      = '0;
                end else begin
                    // Samples fill banks 0..6; a full row of banks advances the row count.
                    if (bank_q == 3'd6) begin
                        bank_d = '0;
                        row_d  = row_q + wADDR'(1);
                    end else begin
                        bank_d = bank_q + 3'd1;
                    end
                    smp_d = smp_q + CNT_W'(1);
                end
            end
            ST_WAIT_RD: begin
                if (tmr_q == TMR_W'(WAIT_RD - 1)) begin
                    state_d  = ST_RD;
                    stage_d  = '0;
                    rd_en_d  = 1'b1;
                    rd_row_d = '0;
                    sop_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RD: begin
                if (rd_row_q == rows_tot_q - wADDR'(1)) begin
                    state_d = ST_WAIT_WR;
                    rd_en_d = 1'b0;
                    tmr_d   = '0;
                end else begin
                    rd_row_d = rd_row_q + wADDR'(1);
                end
            end
            ST_WAIT_WR: begin
                // Drain the butterfly pipeline before the next pass or the output.
                if (tmr_q == TMR_W'(LAT_WR - 1)) begin
                    if (stage_q == ns_q - 3'd1) begin
                        state_d     = ST_SOURCE;
                        src_valid_d = 1'b1;
                        src_cnt_d   = '0;
                    end else begin
                        state_d  = ST_RD;
                        stage_d  = stage_q + 3'd1;
                        rd_en_d  = 1'b1;
                        rd_row_d = '0;
                        sop_d    = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_SOURCE: begin
                if (bus.src_ready) begin
                    if (src_cnt_q == n_q - CNT_W'(1)) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        src_valid_d = 1'b0;
                        src_cnt_d   = '0;
                        stage_d     = '0;
                    end else begin
                        src_cnt_d = src_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_SINK);
    end

    assign bus.fsm         = state_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_row      = rd_row_q;
    assign bus.stage       = stage_q;
    assign bus.stage_sop   = sop_q;
    assign bus.src_valid   = src_valid_q;
    assign bus.src_cnt     = src_cnt_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Testbench for mrd_fsm_ctrl.
// Each frame is expanded into a per-cycle schedule that holds the driven inputs and the expected
// outputs. The expected outputs come from the frame-level rules: N sink cycles, WAIT_RD wait cycles,
// ns passes of ceil(N/7) rows each followed by LAT_WR drain cycles, then N output handshakes.
// A driver process replays the inputs and a compare process checks every output on every cycle.
module tb_mrd_fsm_ctrl;

    localparam int unsigned WADDR   = 8;
    localparam int unsigned WAIT_RD = 4;
    localparam int unsigned LAT_WR  = 16;
    localparam int          NFR     = 16;

    typedef struct {
        bit         rst;
        bit         iv;
        bit         ovt;
        bit [2:0]   nsv;
        bit         rdy;
        int         fid;
        int         fsm;
        bit         in_ready;
        bit         rd_en;
        int         rd_row;
        int         stage;
        bit         sop;
        bit         src_valid;
        int         src_cnt;
        bit         done;
        bit         err;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;

    mrd_fsm_ctrl_if #(.wADDR(WADDR)) bus ();

    mrd_fsm_ctrl #(.wADDR(WADDR), .WAIT_RD(WAIT_RD), .LAT_WR(LAT_WR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    rec_t recs[$];
    int   errors = 0;
    int   checks = 0;
    int   sink_cyc[NFR];
    int   rd_cyc[NFR];
    int   wwr_cyc[NFR];
    int   sop_cnt[NFR];
    int   hs_cnt[NFR];
    int   done_cnt[NFR];
    int   err_cnt[NFR];

    function automatic void chk(string nm, int act, int exp, int cyc);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit rnd_bit();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // Expected output template for a given bus state; unconstrained inputs are randomized.
    function automatic rec_t base(int fid, int f);
        rec_t r;
        r = '{default: 0};
        r.fid      = fid;
        r.fsm      = f;
        r.in_ready = (f == 0) || (f == 1);
        r.nsv      = 3'($urandom_range(0, 7));
        r.rdy      = bit'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic idle_cycles(int fid, int k);
        for (int i = 0; i < k; i++) recs.push_back(base(fid, 0));
    endtask

    // rdy_mode: 0 always ready, 1 ready on every third cycle, 2 random.
    // ovt_at > 0: overTime on that Sink cycle. rst_mid: reset on the second row of stage 1.
    task automatic gen_frame(int fid, int n, int ns_in, int rdy_mode, int ovt_at, bit rst_mid);
        rec_t r;
        int   rows;
        int   nse;
        int   hs;
        int   c;
        rows = (n + 6) / 7;
        nse  = (ns_in == 0) ? 1 : ns_in;

        r = base(fid, 0);
        r.iv  = 1'b1;
        r.nsv = 3'(ns_in);
        recs.push_back(r);

        if (ovt_at > 0) begin
            for (int k = 1; k < ovt_at; k++) begin
                r = base(fid, 1);
                r.iv = 1'b1;
                recs.push_back(r);
            end
            r = base(fid, 1);
            r.iv  = 1'b1;
            r.ovt = 1'b1;
            recs.push_back(r);
            r = base(fid, 0);
            r.err = 1'b1;
            recs.push_back(r);
            return;
        end

        for (int k = 1; k < n; k++) begin
            r = base(fid, 1);
            r.iv = 1'b1;
            recs.push_back(r);
        end
        recs.push_back(base(fid, 1));

        for (int k = 0; k < int'(WAIT_RD); k++) begin
            r = base(fid, 2);
            r.iv = rnd_bit();
            recs.push_back(r);
        end

        for (int s = 0; s < nse; s++) begin
            for (int k = 0; k < rows; k++) begin
                if (rst_mid && s == 1 && k == 1) begin
                    r = base(fid, 0);
                    r.rst = 1'b1;
                    recs.push_back(r);
                    recs.push_back(base(fid, 0));
                    return;
                end
                r = base(fid, 3);
                r.rd_en  = 1'b1;
                r.rd_row = k;
                r.stage  = s;
                r.sop    = (k == 0);
                r.iv     = (rst_mid && s == 1) ? 1'b1 : rnd_bit();
                recs.push_back(r);
            end
            for (int k = 0; k < int'(LAT_WR); k++) begin
                r = base(fid, 4);
                r.stage = s;
                r.iv    = rnd_bit();
                recs.push_back(r);
            end
        end

        hs = 0;
        c  = 0;
        while (hs < n) begin
            r = base(fid, 5);
            r.src_valid = 1'b1;
            r.src_cnt   = hs;
            r.stage     = nse - 1;
            r.iv        = rnd_bit();
            case (rdy_mode)
                0:       r.rdy = 1'b1;
                1:       r.rdy = ((c % 3) == 0);
                default: r.rdy = bit'($urandom_range(0, 1));
            endcase
            if (r.rdy) hs++;
            c++;
            recs.push_back(r);
        end

        r = base(fid, 0);
        r.done = 1'b1;
        recs.push_back(r);
    endtask

    task automatic run_driver();
        for (int i = 0; i < recs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n          = recs[i].rst ? 1'b0 : 1'b1;
            bus.in_valid   = recs[i].iv;
            bus.overTime   = recs[i].ovt;
            bus.num_stages = recs[i].nsv;
            bus.src_ready  = recs[i].rdy;
        end
    endtask

    task automatic run_compare();
        for (int i = 0; i < recs.size(); i++) begin
            rec_t e;
            e = recs[i];
            @(posedge clk);
            @(negedge clk);
            chk("fsm",         int'(bus.fsm),         e.fsm,            i);
            chk("in_ready",    int'(bus.in_ready),    int'(e.in_ready), i);
            chk("rd_en",       int'(bus.rd_en),       int'(e.rd_en),    i);
            chk("stage",       int'(bus.stage),       e.stage,          i);
            chk("stage_sop",   int'(bus.stage_sop),   int'(e.sop),      i);
            chk("src_valid",   int'(bus.src_valid),   int'(e.src_valid), i);
            chk("src_cnt",     int'(bus.src_cnt),     e.src_cnt,        i);
            chk("done",        int'(bus.done),        int'(e.done),     i);
            chk("err_timeout", int'(bus.err_timeout), int'(e.err),      i);
            if (e.rd_en) chk("rd_row", int'(bus.rd_row), e.rd_row, i);

            if (bus.fsm == 3'd1) sink_cyc[e.fid]++;
            if (bus.rd_en) rd_cyc[e.fid]++;
            if (bus.fsm == 3'd4) wwr_cyc[e.fid]++;
            if (bus.stage_sop) sop_cnt[e.fid]++;
            if (bus.src_valid && bus.src_ready) hs_cnt[e.fid]++;
            if (bus.done) done_cnt[e.fid]++;
            if (bus.err_timeout) err_cnt[e.fid]++;
        end
    endtask

    initial begin
        int total_done;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.overTime   = 1'b0;
        bus.num_stages = 3'd0;
        bus.src_ready  = 1'b0;

        idle_cycles(0, 3);
        gen_frame(0, 14, 1, 0, 0, 1'b0);
        idle_cycles(1, 2);
        gen_frame(1, 15, 3, 2, 0, 1'b0);
        gen_frame(2, 0, 2, 0, 2047, 1'b0);
        idle_cycles(3, 2);
        gen_frame(3, 7, 2, 2, 0, 1'b0);
        gen_frame(4, 7, 0, 2, 0, 1'b0);
        gen_frame(5, 21, 2, 1, 0, 1'b0);
        gen_frame(6, 15, 2, 0, 0, 1'b1);
        gen_frame(7, int'($urandom_range(1, 40)), int'($urandom_range(0, 7)), 2, 0, 1'b0);
        for (int f = 8; f < 12; f++) begin
            idle_cycles(f, int'($urandom_range(0, 3)));
            gen_frame(f, int'($urandom_range(1, 40)), int'($urandom_range(0, 7)), 2, 0, 1'b0);
        end
        idle_cycles(12, 3);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fsm",       int'(bus.fsm),         0, -1);
        chk("rst_in_ready",  int'(bus.in_ready),    1, -1);
        chk("rst_rd_en",     int'(bus.rd_en),       0, -1);
        chk("rst_src_valid", int'(bus.src_valid),   0, -1);
        chk("rst_src_cnt",   int'(bus.src_cnt),     0, -1);
        chk("rst_done",      int'(bus.done),        0, -1);
        chk("rst_err",       int'(bus.err_timeout), 0, -1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        fork
            run_driver();
            run_compare();
        join

        // Hand-computed frame totals
        chk("f0_sink_cycles", sink_cyc[0], 14, -1);
        chk("f0_rd_cycles",   rd_cyc[0],   2,  -1);
        chk("f0_sop",         sop_cnt[0],  1,  -1);
        chk("f0_handshakes",  hs_cnt[0],   14, -1);
        chk("f0_done",        done_cnt[0], 1,  -1);
        chk("f1_sink_cycles", sink_cyc[1], 15, -1);
        chk("f1_rd_cycles",   rd_cyc[1],   9,  -1);
        chk("f1_drain",       wwr_cyc[1],  48, -1);
        chk("f1_sop",         sop_cnt[1],  3,  -1);
        chk("f2_sink_cycles", sink_cyc[2], 2047, -1);
        chk("f2_err",         err_cnt[2],  1,  -1);
        chk("f2_done",        done_cnt[2], 0,  -1);
        chk("f3_handshakes",  hs_cnt[3],   7,  -1);
        chk("f4_rd_cycles",   rd_cyc[4],   1,  -1);
        chk("f4_sop",         sop_cnt[4],  1,  -1);
        chk("f5_handshakes",  hs_cnt[5],   21, -1);
        chk("f5_done",        done_cnt[5], 1,  -1);
        chk("f6_rd_cycles",   rd_cyc[6],   4,  -1);
        chk("f6_done",        done_cnt[6], 0,  -1);
        total_done = 0;
        for (int f = 0; f < NFR; f++) total_done += done_cnt[f];
        chk("total_done",     total_done,  10, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
